// File: rtl/ser_demux_pkg.sv
// ser_demux_pkg: shared FSM state type and width helper for the serial demultiplexer.
// Contents: state_t (frame-parser states), clog2() for header field widths.
package ser_demux_pkg;

    typedef enum logic [2:0] {IDLE, PORT, LEN, DATA, PAR, DONE} state_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/ser_shreg.sv
// ser_shreg: MSB-first serial-to-parallel header register.
// Ports: clk, rst (async active-low), clkEn (bit strobe), shEn (shift enable),
//        din (serial bit), q (parallel value, last bit received in q[0]).
module ser_shreg
    import ser_demux_pkg::*;
#(
    parameter int W = 2
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         clkEn,
    input  logic         shEn,
    input  logic         din,
    output logic [W-1:0] q
);

    // Concatenate then truncate so W=1 needs no special case.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (clkEn && shEn) q <= W'({q, din});
    end

endmodule

// File: rtl/ser_demux_n.sv
// ser_demux_n: parses serial frames (start, port, length, payload[, parity]) and steers payload bits to one of NUM_PORTS outputs.
// Ports: clk, rst (async active-low), clkEn (bit strobe), serIn (serial in, idle high),
//        dataOut/dataValid (per-port bit and one-hot strobe), portNum (latched port),
//        busy (not IDLE), done (end-of-frame pulse), parErr (parity-error pulse).
// Option: define SER_DEMUX_PARITY_EN to add the even-parity bit, the PAR state and the parErr port.
module ser_demux_n
    import ser_demux_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int LEN_W     = 4,
    localparam int PORT_W    = clog2(NUM_PORTS)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkEn,
    input  logic                 serIn,
    output logic [NUM_PORTS-1:0] dataOut,
    output logic [NUM_PORTS-1:0] dataValid,
    output logic [PORT_W-1:0]    portNum,
    output logic                 busy,
    output logic                 done
`ifdef SER_DEMUX_PARITY_EN
    ,
    output logic                 parErr
`endif
);

    localparam int CNT_W = PORT_W > LEN_W ? PORT_W : LEN_W;

    // State entered once the header/payload is exhausted.
`ifdef SER_DEMUX_PARITY_EN
    localparam state_t END_ST = PAR;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LEN_W-1:0]   dcnt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_nx;
    logic [PORT_W-1:0]  port_q;

    // Length including the bit being shifted in on the final LEN strobe.
    assign len_nx  = LEN_W'({len_q, serIn});
    assign portNum = port_q;

    ser_shreg #(.W(PORT_W)) u_port (
        .clk   (clk),
        .rst   (rst),
        .clkEn (clkEn),
        .shEn  (state == PORT),
        .din   (serIn),
        .q     (port_q)
    );

    ser_shreg #(.W(LEN_W)) u_len (
        .clk   (clk),
        .rst   (rst),
        .clkEn (clkEn),
        .shEn  (state == LEN),
        .din   (serIn),
        .q     (len_q)
    );

    always_comb begin
        dataOut   = '0;
        dataValid = '0;
        if (state == DATA && clkEn) begin
            dataOut[portNum]   = serIn;
            dataValid[portNum] = 1'b1;
        end
    end

`ifdef SER_DEMUX_PARITY_EN
    logic par;

    // Running XOR of port, length and payload bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par <= 1'b0;
        else if (clkEn) begin
            if (state == IDLE) par <= 1'b0;
            else if (state == PORT || state == LEN || state == DATA) par <= par ^ serIn;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SER_DEMUX_PARITY_EN
            parErr <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SER_DEMUX_PARITY_EN
            parErr <= 1'b0;
`endif
            case (state)
                IDLE: if (clkEn && !serIn) begin
                    state <= PORT;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
                PORT: if (clkEn) begin
                    cnt <= (cnt == CNT_W'(PORT_W - 1)) ? '0 : cnt + 1'b1;
                    if (cnt == CNT_W'(PORT_W - 1)) state <= LEN;
                end
                LEN: if (clkEn) begin
                    cnt <= (cnt == CNT_W'(LEN_W - 1)) ? '0 : cnt + 1'b1;
                    if (cnt == CNT_W'(LEN_W - 1)) begin
                        dcnt <= len_nx;
                        if (len_nx != '0) state <= DATA;
                        else begin
                            state <= END_ST;
                            done  <= (END_ST == DONE);
                        end
                    end
                end
                DATA: if (clkEn) begin
                    dcnt <= dcnt - 1'b1;
                    if (dcnt == LEN_W'(1)) begin
                        state <= END_ST;
                        done  <= (END_ST == DONE);
                    end
                end
`ifdef SER_DEMUX_PARITY_EN
                // Even parity: the received bit must equal the running XOR.
                PAR: if (clkEn) begin
                    state  <= DONE;
                    done   <= 1'b1;
                    parErr <= par ^ serIn;
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_demux_n.sv
// tb_ser_demux_n: self-checking bench for ser_demux_n (4-port/LEN_W=4 and 8-port/LEN_W=5 instances).
module tb_ser_demux_n;

    logic       clk = 1'b0;
    logic       rst, en, s4, s8;
    logic [3:0] d4, v4;
    logic [1:0] p4;
    logic       b4, dn4;
    logic [7:0] d8, v8;
    logic [2:0] p8;
    logic       b8, dn8;
`ifdef SER_DEMUX_PARITY_EN
    logic       pe4, pe8;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit obs4[$];
    bit obs8[$];
    int vport[2], bad[2], done_n[2], done_cyc[2], pe_n[2];

    ser_demux_n u4 (
        .clk(clk), .rst(rst), .clkEn(en), .serIn(s4), .dataOut(d4), .dataValid(v4),
        .portNum(p4), .busy(b4), .done(dn4)
`ifdef SER_DEMUX_PARITY_EN
        , .parErr(pe4)
`endif
    );

    ser_demux_n #(.NUM_PORTS(8), .LEN_W(5)) u8 (
        .clk(clk), .rst(rst), .clkEn(en), .serIn(s8), .dataOut(d8), .dataValid(v8),
        .portNum(p8), .busy(b8), .done(dn8)
`ifdef SER_DEMUX_PARITY_EN
        , .parErr(pe8)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collect delivered payload bits and protocol violations, sampled mid-cycle.
    always @(negedge clk) begin
        if (v4 != '0) begin
            if (!$onehot(v4) || !en) bad[0]++;
            for (int i = 0; i < 4; i++) if (v4[i]) begin
                if (vport[0] >= 0 && vport[0] != i) bad[0]++;
                vport[0] = i;
                obs4.push_back(d4[i]);
            end
        end
        if ((d4 & ~v4) != '0) bad[0]++;
        if (dn4) begin done_n[0]++; done_cyc[0] = cyc; end
`ifdef SER_DEMUX_PARITY_EN
        if (pe4) begin pe_n[0]++; if (!dn4) bad[0]++; end
`endif
    end

    always @(negedge clk) begin
        if (v8 != '0) begin
            if (!$onehot(v8) || !en) bad[1]++;
            for (int j = 0; j < 8; j++) if (v8[j]) begin
                if (vport[1] >= 0 && vport[1] != j) bad[1]++;
                vport[1] = j;
                obs8.push_back(d8[j]);
            end
        end
        if ((d8 & ~v8) != '0) bad[1]++;
        if (dn8) begin done_n[1]++; done_cyc[1] = cyc; end
`ifdef SER_DEMUX_PARITY_EN
        if (pe8) begin pe_n[1]++; if (!dn8) bad[1]++; end
`endif
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Present one bit and hold it until a strobe (clkEn=1 on every per-th cycle) consumes it.
    task automatic drive_bit(input int w, input bit b, input int per);
        bit e;
        if (w != 0) s8 = b; else s4 = b;
        do begin
            e  = ((cyc + 1) % per == 0);
            en = e;
            @(posedge clk);
            #1;
        end while (!e);
    endtask

    // Send a whole frame and compare what came out against the frame's own contents.
    task automatic send(input int w, input int port, input int len, input logic [31:0] pay,
                        input int per, input bit corrupt);
        int     pw, lw, last, g, expv;
        longint m;
        bit     par;
        bit     bits[$];
        bit     got[$];
        pw  = (w != 0) ? 3 : 2;
        lw  = (w != 0) ? 5 : 4;
        par = 1'b0;
        if (w != 0) obs8.delete(); else obs4.delete();
        vport[w] = -1; bad[w] = 0; done_n[w] = 0; done_cyc[w] = -1; pe_n[w] = 0;
        bits.push_back(1'b0);
        for (int i = pw - 1; i >= 0; i--) bits.push_back(port[i]);
        for (int i = lw - 1; i >= 0; i--) bits.push_back(len[i]);
        for (int i = 0; i < len; i++) bits.push_back(pay[i]);
        foreach (bits[i]) par ^= bits[i];
`ifdef SER_DEMUX_PARITY_EN
        bits.push_back(par ^ corrupt);
`else
        if (corrupt) par = ~par;
`endif
        foreach (bits[i]) drive_bit(w, bits[i], per);
        last = cyc;
        en = 1'b1;
        if (w != 0) s8 = 1'b1; else s4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (w != 0) got = obs8; else got = obs4;
        g = 0;
        foreach (got[i]) if (i < 32) g[i] = got[i];
        m    = (longint'(1) << len) - 1;
        expv = int'(longint'(pay) & m);
        chk($sformatf("w%0d size", w), got.size(), len);
        chk($sformatf("w%0d data", w), g, expv);
        chk($sformatf("w%0d port seen", w), vport[w], (len != 0) ? port : -1);
        chk($sformatf("w%0d protocol", w), bad[w], 0);
        chk($sformatf("w%0d done count", w), done_n[w], 1);
        chk($sformatf("w%0d done cycle", w), done_cyc[w], last);
        chk($sformatf("w%0d portNum", w), (w != 0) ? int'(p8) : int'(p4), port);
        chk($sformatf("w%0d busy idle", w), (w != 0) ? int'(b8) : int'(b4), 0);
`ifdef SER_DEMUX_PARITY_EN
        chk($sformatf("w%0d parErr", w), pe_n[w], int'(corrupt));
`endif
    endtask

    initial begin
        int w, port, len;
        rst = 1'b0;
        en  = 1'b0;
        s4  = 1'b1;
        s8  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst valid4", int'(v4), 0);
        chk("rst data4", int'(d4), 0);
        chk("rst port4", int'(p4), 0);
        chk("rst busy4", int'(b4), 0);
        chk("rst done4", int'(dn4), 0);
        chk("rst valid8", int'(v8), 0);
        chk("rst busy8", int'(b8), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(0, 2, 3, 32'h5, 1, 1'b0);
        send(0, 1, 0, 32'h0, 1, 1'b0);
        send(0, 2, 3, 32'h5, 3, 1'b0);

        // Mid-DATA reset on a frame to port 3 with length 10.
        drive_bit(0, 1'b0, 1);
        drive_bit(0, 1'b1, 1);
        drive_bit(0, 1'b1, 1);
        drive_bit(0, 1'b1, 1);
        drive_bit(0, 1'b0, 1);
        drive_bit(0, 1'b1, 1);
        drive_bit(0, 1'b0, 1);
        drive_bit(0, 1'b1, 1);
        drive_bit(0, 1'b0, 1);
        s4 = 1'b1;
        en = 1'b1;
        #1;
        chk("mid valid", int'(v4), 8);
        chk("mid data", int'(d4), 8);
        chk("mid busy", int'(b4), 1);
        rst = 1'b0;
        #1;
        chk("async valid", int'(v4), 0);
        chk("async data", int'(d4), 0);
        chk("async port", int'(p4), 0);
        chk("async busy", int'(b4), 0);
        chk("async done", int'(dn4), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(0, 0, 6, $urandom, 1, 1'b0);

        send(1, 7, 31, $urandom, 1, 1'b0);

`ifdef SER_DEMUX_PARITY_EN
        send(0, 1, 4, $urandom, 1, 1'b1);
        send(0, 1, 4, $urandom, 1, 1'b0);
`endif

        for (int n = 0; n < 16; n++) begin
            w    = int'($urandom_range(0, 1));
            port = int'($urandom_range(0, (w != 0) ? 7 : 3));
            len  = int'($urandom_range(0, (w != 0) ? 31 : 15));
            send(w, port, len, $urandom, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_demux_n.md
SER_DEMUX_N -- requirements
Module: ser_demux_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of output ports; power of two, 2..16.
REQ-002 SHALL have parameter LEN_W, default 4, width of the payload-length header field.
REQ-003 SHALL have derived localparam PORT_W = clog2(NUM_PORTS), width of the port header field.
REQ-004 SHALL have port: clk  in  1  single rising-edge clock.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: clkEn  in  1  bit strobe; state advances only on cycles with clkEn=1.
REQ-007 SHALL have port: serIn  in  1  serial input, idle high.
REQ-008 SHALL have port: dataOut  out  NUM_PORTS  per-port serial data, valid only where the matching dataValid bit is 1.
REQ-009 SHALL have port: dataValid  out  NUM_PORTS  one-hot per-port bit-valid strobe.
REQ-010 SHALL have port: portNum  out  PORT_W  latched destination port.
REQ-011 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port: done  out  1  single-cycle end-of-frame pulse.
REQ-013 SHALL have port: parErr  out  1  parity-error pulse; present only under SER_DEMUX_PARITY_EN.

Function
REQ-014 SHALL implement frame format: start bit (0), PORT_W port bits MSB first, LEN_W length bits MSB first, LEN payload bits, optional parity bit.
REQ-015 SHALL implement FSM states IDLE, PORT, LEN, DATA, PAR, DONE.
REQ-016 SHALL make all transitions, other than DONE->IDLE, only on clkEn=1 cycles.
REQ-017 SHALL take IDLE->PORT when serIn=0; IDLE SHALL hold while serIn=1.
REQ-018 SHALL shift serIn into the port register in PORT; after exactly PORT_W strobes, go to LEN.
REQ-019 SHALL shift serIn into the length register in LEN; after LEN_W strobes, go to DATA when length>0.
REQ-020 SHALL skip DATA after LEN when length=0: to PAR if parity is enabled, else to DONE.
REQ-021 SHALL, in DATA on each strobe, drive dataOut[portNum]=serIn and dataValid[portNum]=1 combinationally; all other ports SHALL be 0.
REQ-022 SHALL decrement the down-counter on each DATA strobe; leaving DATA happens on the strobe where the counter is 1.
REQ-023 SHALL support maximum payload 2^LEN_W-1 bits; the counter SHALL not wrap.
REQ-024 SHALL hold dataValid at 0 outside DATA and on DATA cycles with clkEn=0.
REQ-025 SHALL assert done for exactly one clk cycle in DONE, regardless of clkEn, then return to IDLE.
REQ-026 SHALL keep portNum stable from the end of PORT until the next frame's PORT.
REQ-027 SHALL not re-detect a start bit in DONE; start detection SHALL begin from IDLE on the next clkEn=1 cycle.

Reset
REQ-028 SHALL, on rst=0 at any time (including mid-frame), force immediately: state=IDLE, counters=0, portNum=0, dataOut=0, dataValid=0, busy=0, done=0, parErr=0.
REQ-029 SHALL, after release, ignore the partial frame; the first serIn=0 strobe starts a new frame.

Configuration
REQ-030 SHALL use macro SER_DEMUX_PARITY_EN: when defined, PAR state samples one even-parity bit over port, length and payload bits.
REQ-031 SHALL, on parity mismatch, assert parErr together with done for the same single cycle.
REQ-032 SHALL, when SER_DEMUX_PARITY_EN is undefined, omit PAR and the parErr port; LEN/DATA go directly to DONE.

Structure
REQ-033 SHALL place the state enum typedef and the clog2-derived width helper in package ser_demux_pkg.
REQ-034 SHALL implement the header shifting with sub-module ser_shreg (parameter W, inputs clkEn and shEn, parallel output), instantiated for port and length.

Verification
REQ-035 SHALL cover: NUM_PORTS=4, frame 0,10,0011,101 -> dataValid[2] high on 3 strobes, dataOut[2]=1,0,1, then done for 1 cycle.
REQ-036 SHALL cover: length=0000 to port 1 -> no dataValid, done 1 cycle after last length bit's strobe.
REQ-037 SHALL cover: clkEn toggled every 3rd cycle, same frame as REQ-035 -> identical bit sequence; no valid on clkEn=0 cycles.
REQ-038 SHALL cover: rst pulsed low during DATA of port 3 -> all outputs 0 immediately; next full frame to port 0 delivered correctly.
REQ-039 SHALL cover: NUM_PORTS=8, LEN_W=5, length=31 to port 7 -> 31 valid strobes on port 7 only.
REQ-040 SHALL cover: with SER_DEMUX_PARITY_EN, frame with wrong parity bit -> parErr and done high in the same cycle; correct parity -> parErr=0.
